// File: rtl/ransac_pkg.sv
// Shared RANSAC bus types: AXI response codes and AXI4-Lite word geometry.
// Types and constants only; no logic, no timing.
package ransac;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_value_e;

  localparam int AXI_LITE_WORD_BYTES = 4;

endpackage

// File: rtl/point_responder_fifo.sv
// Synchronous FIFO with count. The head entry is visible the cycle after it is pushed.
// Push and pop in the same cycle succeed even when full; a pop on empty is ignored.
module point_responder_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             head_vld,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = count == CNT_W'(DEPTH);
  assign head_vld = count != '0;
  assign head_dat = mem[rptr];
  assign do_pop   = pop && head_vld;
  // When full, the pop frees the very slot the push lands in.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_dat;
        wptr      <= ptr_next(wptr);
      end
      if (do_pop) rptr <= ptr_next(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/point_buffer_axi_responder.sv
// AXI4-Lite read responder over a point-cloud RAM: AR decode, one RAM stage, then a response FIFO.
// An AR handshake gives R valid 2 cycles later; AR stalls while FIFO plus in-flight entries fill FIFO_DEPTH.
module point_buffer_axi_responder
  import ransac::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    FIFO_DEPTH  = 4,
  localparam int                   IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output axi_resp_value_e       s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic                  load_en,
  input  logic [IDX_W-1:0]      load_index,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_clear,
  output logic [IDX_W:0]        loaded_words,
  output logic [31:0]           reads_ok,
  output logic [31:0]           reads_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 2 + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH_WORDS * AXI_LITE_WORD_BYTES);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] ram_rd_dat;
  logic [ADDR_WIDTH-1:0] ar_off;
  logic [IDX_W-1:0]      ar_word;
  logic                  ar_in_range, ar_aligned, ar_loaded, ar_hs, r_hs;
  axi_resp_value_e       ar_resp, s1_resp;
  logic                  s1_vld, rst_done;
  logic [ENT_W-1:0]      push_dat, head_dat;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occupancy;
  logic [IDX_W:0]        load_ext;

  // Subtraction wraps for addresses below the base, so range needs both bounds.
  assign ar_off      = s_araddr - BASE_ADDR;
  assign ar_in_range = (s_araddr >= BASE_ADDR) && ({1'b0, ar_off} < SPAN);
  assign ar_word     = ar_off[IDX_W+1:2];
  assign ar_aligned  = ar_off[1:0] == 2'b00;
  assign ar_loaded   = {1'b0, ar_word} < loaded_words;

  always_comb begin
    ar_resp = AXI_OKAY;
    if (!ar_in_range)                 ar_resp = AXI_DECERR;
    else if (!ar_aligned || !ar_loaded) ar_resp = AXI_SLVERR;
  end

  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(s1_vld);
  assign s_arready = rst_done && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign ar_hs     = s_arvalid && s_arready;
  assign r_hs      = s_rvalid && s_rready;

  // Read-first: a same-cycle load to the read word is not seen by this read.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_index] <= load_data;
    if (ar_hs)   ram_rd_dat      <= mem[ar_word];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_done <= 1'b0;
      s1_vld   <= 1'b0;
      s1_resp  <= AXI_OKAY;
    end else begin
      rst_done <= 1'b1;
      s1_vld   <= ar_hs;
      if (ar_hs) s1_resp <= ar_resp;
    end
  end

  assign push_dat = {s1_resp, (s1_resp == AXI_OKAY) ? ram_rd_dat : '0};

  point_responder_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (s1_vld),
    .push_dat (push_dat),
    .pop      (s_rready),
    .head_dat (head_dat),
    .head_vld (s_rvalid),
    .count    (fifo_count)
  );

  assign s_rresp = axi_resp_value_e'(head_dat[ENT_W-1 -: 2]);
  assign s_rdata = head_dat[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      reads_ok  <= '0;
      reads_err <= '0;
    end else if (r_hs) begin
      if (s_rresp == AXI_OKAY) begin
        if (reads_ok != '1) reads_ok <= reads_ok + 32'd1;
      end else if (reads_err != '1) begin
        reads_err <= reads_err + 32'd1;
      end
    end
  end

  assign load_ext = {1'b0, load_index} + (IDX_W + 1)'(1);

  always_ff @(posedge clk) begin
    if (rst)                                 loaded_words <= '0;
    else if (load_clear)                     loaded_words <= load_en ? load_ext : '0;
    else if (load_en && load_ext > loaded_words) loaded_words <= load_ext;
  end

endmodule

// File: tb/tb_point_buffer_axi_responder.sv
// Directed bench for point_buffer_axi_responder: decode table plus streaming, backpressure,
// collision and reset sequences.
module tb_point_buffer_axi_responder;
  import ransac::*;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 1024;
  localparam int          FD    = 4;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic          clk, rst;
  logic [AW-1:0] s_araddr;
  logic          s_arvalid, s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid, s_rready;
  logic          load_en, load_clear;
  logic [9:0]    load_index;
  logic [DW-1:0] load_data;
  logic [10:0]   loaded_words;
  logic [31:0]   reads_ok, reads_err;

  point_buffer_axi_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .load_en(load_en), .load_index(load_index), .load_data(load_data), .load_clear(load_clear),
    .loaded_words(loaded_words), .reads_ok(reads_ok), .reads_err(reads_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic word_addr(input int w, output logic [31:0] a);
    a = BASE + 32'(w * 4);
  endtask

  // One read: waits (bounded) for AR, returns response, data and cycles from AR handshake to R valid.
  task automatic rd(input logic [31:0] a, output logic [1:0] r, output logic [31:0] d, output int lat);
    int n;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (!s_arready && n < 20) begin @(negedge clk); n++; end
    check("ar_accept_in_budget", 32'(n < 20), 32'd1);
    @(posedge clk); #1 s_arvalid = 1'b0;
    lat = 0; r = 2'b00; d = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (s_rvalid) begin lat = k; r = s_rresp; d = s_rdata; break; end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  resp;
    logic [31:0] data;
    int          ok;
    int          err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d, a;
    int lat, got, first_c, last_c, arlow, idx, stale;
    logic acc;

    vecs[0] = '{BASE + 32'h10,   AXI_OKAY,   32'hA000_0004, 1, 0};
    vecs[1] = '{BASE + 32'h02,   AXI_SLVERR, 32'h0,         1, 1};
    vecs[2] = '{BASE + 32'h1000, AXI_DECERR, 32'h0,         1, 2};
    vecs[3] = '{BASE + 32'h20,   AXI_SLVERR, 32'h0,         1, 3};
    vecs[4] = '{BASE + 32'h1C,   AXI_OKAY,   32'hA000_0007, 2, 3};
    vecs[5] = '{BASE - 32'h4,    AXI_DECERR, 32'h0,         2, 4};
    vecs[6] = '{BASE + 32'h1003, AXI_DECERR, 32'h0,         2, 5};
    vecs[7] = '{BASE + 32'h00,   AXI_OKAY,   32'hA000_0000, 3, 5};
    vecs[8] = '{BASE + 32'hFFC,  AXI_SLVERR, 32'h0,         3, 6};

    rst = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    load_en = 1'b0; load_clear = 1'b0; load_index = '0; load_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 32'(s_arready), 32'd0);
    check("rst_rvalid", 32'(s_rvalid), 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    check("rst_rresp", 32'(s_rresp), 32'(AXI_OKAY));
    check("rst_loaded", 32'(loaded_words), 32'd0);
    check("rst_ok", reads_ok, 32'd0);
    check("rst_err", reads_err, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("arready_first_cycle", 32'(s_arready), 32'd0);
    @(negedge clk);
    check("arready_after", 32'(s_arready), 32'd1);

    // Load words 0..7
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_index = 10'(i); load_data = 32'hA000_0000 + 32'(i);
    end
    @(negedge clk); load_en = 1'b0;
    check("loaded_8", 32'(loaded_words), 32'd8);

    // Decode table
    for (int i = 0; i < 9; i++) begin
      rd(vecs[i].addr, r, d, lat);
      check($sformatf("v%0d_resp", i), 32'(r), 32'(vecs[i].resp));
      check($sformatf("v%0d_data", i), d, vecs[i].data);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("v%0d_ok", i), reads_ok, 32'(vecs[i].ok));
      check($sformatf("v%0d_err", i), reads_err, 32'(vecs[i].err));
    end

    // Back-to-back streaming: 16 reads, one beat per cycle
    got = 0; first_c = 0; last_c = 0; arlow = 0;
    s_rready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          word_addr(i % 8, a);
          s_araddr = a; s_arvalid = 1'b1;
          if (!s_arready) arlow++;
          @(posedge clk);
        end
        #1 s_arvalid = 1'b0;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (s_rvalid) begin
            check($sformatf("b2b_data%0d", got), s_rdata, 32'hA000_0000 + 32'(got % 8));
            check($sformatf("b2b_resp%0d", got), 32'(s_rresp), 32'(AXI_OKAY));
            if (got == 0) first_c = cyc;
            last_c = cyc;
            got++;
          end
        end
      end
    join
    check("b2b_count", 32'(got), 32'd16);
    check("b2b_consecutive", 32'(last_c - first_c), 32'd15);
    check("b2b_arready_low", 32'(arlow), 32'd0);
    check("b2b_ok", reads_ok, 32'd19);

    // Backpressure: FIFO fills to exactly FIFO_DEPTH
    s_rready = 1'b0; idx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      word_addr(idx, a);
      s_araddr = a; s_arvalid = 1'b1;
      acc = s_arready;
      @(posedge clk);
      if (acc) idx++;
    end
    check("bp_accepted", 32'(idx), 32'(FD));
    @(negedge clk);
    check("bp_arready", 32'(s_arready), 32'd0);
    check("bp_rvalid", 32'(s_rvalid), 32'd1);
    check("bp_head_data", s_rdata, 32'hA000_0000);
    repeat (2) @(negedge clk);
    check("bp_hold_data", s_rdata, 32'hA000_0000);
    check("bp_hold_resp", 32'(s_rresp), 32'(AXI_OKAY));
    s_arvalid = 1'b0; s_rready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      if (j == 1) check("bp_arready_after_pop", 32'(s_arready), 32'd1);
      check($sformatf("bp_rvalid%0d", j), 32'(s_rvalid), 32'd1);
      check($sformatf("bp_data%0d", j), s_rdata, 32'hA000_0000 + 32'(j));
    end
    @(negedge clk);
    check("bp_drained", 32'(s_rvalid), 32'd0);
    check("bp_ok", reads_ok, 32'd23);

    // Load and read of word 3 in the same cycle returns the old value
    @(negedge clk);
    load_en = 1'b1; load_index = 10'd3; load_data = 32'hDEAD_BEEF;
    word_addr(3, a);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    check("coll_arready", 32'(s_arready), 32'd1);
    @(posedge clk); #1 load_en = 1'b0; s_arvalid = 1'b0;
    lat = 0; d = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (s_rvalid) begin lat = k; d = s_rdata; break; end
    end
    @(posedge clk); #1;
    check("coll_latency", 32'(lat), 32'd2);
    check("coll_old_data", d, 32'hA000_0003);
    rd(a, r, d, lat);
    check("coll_new_data", d, 32'hDEAD_BEEF);
    check("coll_ok", reads_ok, 32'd25);

    // Reset with three beats outstanding
    s_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      word_addr(i, a);
      s_araddr = a; s_arvalid = 1'b1;
      @(posedge clk);
    end
    #1 s_arvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_rvalid", 32'(s_rvalid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rvalid", 32'(s_rvalid), 32'd0);
    check("mid_rst_ok", reads_ok, 32'd0);
    check("mid_rst_err", reads_err, 32'd0);
    check("mid_rst_loaded", 32'(loaded_words), 32'd0);
    @(posedge clk); #1 rst = 1'b0; s_rready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (s_rvalid) stale++;
    end
    check("no_stale_beats", 32'(stale), 32'd0);

    // Nothing is loaded, so word 0 is now an error
    rd(BASE, r, d, lat);
    check("post_rst_resp", 32'(r), 32'(AXI_SLVERR));
    check("post_rst_data", d, 32'd0);
    check("post_rst_err", reads_err, 32'd1);

    // Loaded extent: max tracking, clear with load, plain clear
    @(negedge clk); load_en = 1'b1; load_index = 10'd5; load_data = 32'h5;
    @(negedge clk); load_index = 10'd2;
    @(negedge clk); load_en = 1'b0;
    check("extent_max", 32'(loaded_words), 32'd6);
    load_clear = 1'b1; load_en = 1'b1; load_index = 10'd1;
    @(negedge clk); load_clear = 1'b0; load_en = 1'b0;
    check("extent_clear_load", 32'(loaded_words), 32'd2);
    load_clear = 1'b1;
    @(negedge clk); load_clear = 1'b0;
    check("extent_clear", 32'(loaded_words), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
